// File: rtl/axi_lite_req_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite master port between
// NUM_REQ local requesters using a simple req/done command interface.
// Only one transaction is in flight at a time: a write (AW+W, then B)
// or a read (AR, then R).
//
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   req, req_we             per-requester request (held until done), 1=write
//   req_addr/wdata/wstrb    flattened per-requester command fields
//   done                    one-cycle completion pulse to the granted requester
//   rsp_rdata, rsp_resp     last captured read data / response code
//   busy, gnt_id            transaction in progress, current/last grant
//   aw*, w*, b*, ar*, r*    AXI4-Lite master channels
//
// state   | meaning
// IDLE    | waiting for any req; picks next requester after gnt_id
// WR_AW_W | AW and W offered; each channel retires independently
// WR_B    | waiting for write response
// RD_AR   | AR offered, held until arready
// RD_R    | waiting for read data
// DONE    | done[gnt_id] pulses for this single cycle
module axi_lite_req_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   input  logic [NUM_REQ*STRB_WIDTH-1:0] req_wstrb,
   output logic [NUM_REQ-1:0]            done,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic [1:0]                    rsp_resp,
   output logic                          busy,
   output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
   output logic [ADDR_WIDTH-1:0]         awaddr,
   output logic                          awvalid,
   input  logic                          awready,
   output logic [DATA_WIDTH-1:0]         wdata,
   output logic [STRB_WIDTH-1:0]         wstrb,
   output logic                          wvalid,
   input  logic                          wready,
   input  logic [1:0]                    bresp,
   input  logic                          bvalid,
   output logic                          bready,
   output logic [ADDR_WIDTH-1:0]         araddr,
   output logic                          arvalid,
   input  logic                          arready,
   input  logic [DATA_WIDTH-1:0]         rdata,
   input  logic [1:0]                    rresp,
   input  logic                          rvalid,
   output logic                          rready
);

   localparam int IDW = $clog2(NUM_REQ);

   typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, DONE} state_t;
   state_t state;

   logic                  pick_vld;
   logic [IDW-1:0]        pick_idx;
   logic [IDW-1:0]        cand;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [STRB_WIDTH-1:0] sel_wstrb;

   // Scan downward from the farthest candidate so the nearest requester
   // after gnt_id is the last (winning) assignment.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = IDW'((int'(gnt_id) + i) % NUM_REQ);
         if (req[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wstrb = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == IDW'(i)) begin
            sel_we    = req_we[i];
            sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_wstrb = req_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state     <= IDLE;
         awaddr    <= '0;
         awvalid   <= 1'b0;
         wdata     <= '0;
         wstrb     <= '1;
         wvalid    <= 1'b0;
         bready    <= 1'b0;
         araddr    <= '0;
         arvalid   <= 1'b0;
         rready    <= 1'b0;
         done      <= '0;
         rsp_rdata <= '0;
         rsp_resp  <= '0;
         busy      <= 1'b0;
         gnt_id    <= IDW'(NUM_REQ - 1);
      end else begin
         done <= '0;
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  gnt_id <= pick_idx;
                  busy   <= 1'b1;
                  if (sel_we) begin
                     awaddr  <= sel_addr;
                     wdata   <= sel_wdata;
                     wstrb   <= sel_wstrb;
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                     state   <= WR_AW_W;
                  end else begin
                     araddr  <= sel_addr;
                     arvalid <= 1'b1;
                     state   <= RD_AR;
                  end
               end
            end
            WR_AW_W: begin
               if (awvalid && awready) awvalid <= 1'b0;
               if (wvalid && wready)   wvalid  <= 1'b0;
               // Both channels retired (earlier or on this edge).
               if (!(awvalid && !awready) && !(wvalid && !wready)) begin
                  bready <= 1'b1;
                  state  <= WR_B;
               end
            end
            WR_B: begin
               if (bvalid && bready) begin
                  rsp_resp     <= bresp;
                  bready       <= 1'b0;
                  done[gnt_id] <= 1'b1;
                  state        <= DONE;
               end
            end
            RD_AR: begin
               if (arvalid && arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= RD_R;
               end
            end
            RD_R: begin
               if (rvalid && rready) begin
                  rsp_rdata    <= rdata;
                  rsp_resp     <= rresp;
                  rready       <= 1'b0;
                  done[gnt_id] <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
